// File: rtl/fix_to_float_seq.sv
// Sequential Q16.16 unsigned to IEEE-754 single converter; one shared 16-bit priority encoder scans both operand halves.
// Optional round-to-nearest-even in SHIFT when FIX2FLT_ROUND_RNE_EN is defined (truncation otherwise).
module priority_encoder #(
    parameter int WIDTH = 16,
    parameter int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [OUT_W-1:0] idx
);
    // Highest set bit wins; all-zero input also yields 0.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (vec[i]) idx = OUT_W'(i);
    end
endmodule

module fix_to_float_seq #(
    parameter int DATA_W    = 32,
    parameter int ENC_W     = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              busy
);
    localparam int POS_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(ENC_W);

    typedef enum logic [2:0] {IDLE, SCAN_HI, SCAN_LO, SHIFT, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] opnd;
    logic [POS_W-1:0]  pos;
    logic [ENC_W-1:0]  enc_in;
    logic [IDX_W-1:0]  enc_out;
    logic              hit;
    logic [POS_W-1:0]  shamt;
    logic [7:0]        expo, expo_f;
    logic [22:0]       mant_f;

    priority_encoder #(.WIDTH(ENC_W)) u_enc (.vec(enc_in), .idx(enc_out));

    always_comb begin
        enc_in = '0;
        case (state)
            SCAN_HI: enc_in = opnd[DATA_W-1:ENC_W];
            SCAN_LO: enc_in = opnd[ENC_W-1:0];
            default: enc_in = '0;
        endcase
    end

    // The encoder cannot distinguish "zero" from "bit 0 set"; decide zero here.
    assign hit   = |enc_in;
    assign shamt = POS_W'(DATA_W - 1) - pos;
    assign expo  = 8'(pos) + 8'(127 - FRAC_BITS);

`ifdef FIX2FLT_ROUND_RNE_EN
    logic [DATA_W-1:0] norm;
    logic [23:0]       mant_r;
    logic              rnd_up;
    assign norm   = opnd << shamt;
    assign rnd_up = norm[DATA_W-25] & ((|norm[DATA_W-26:0]) | norm[DATA_W-24]);
    assign mant_r = {1'b0, norm[DATA_W-2:DATA_W-24]} + 24'(rnd_up);
    // Carry out of the mantissa means 1.111..1 rounded up to 2.0.
    assign mant_f = mant_r[23] ? 23'd0 : mant_r[22:0];
    assign expo_f = mant_r[23] ? expo + 8'd1 : expo;
`else
    assign mant_f = 23'((opnd << shamt) >> (DATA_W - 24));
    assign expo_f = expo;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opnd      <= '0;
            pos       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    opnd     <= in_data;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= SCAN_HI;
                end
                SCAN_HI: if (hit) begin
                    pos   <= POS_W'(ENC_W) + POS_W'(enc_out);
                    state <= SHIFT;
                end else begin
                    state <= SCAN_LO;
                end
                SCAN_LO: if (hit) begin
                    pos   <= POS_W'(enc_out);
                    state <= SHIFT;
                end else begin
                    out_data  <= '0;
                    out_zero  <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                SHIFT: begin
                    out_data  <= {1'b0, expo_f, mant_f};
                    out_zero  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fix_to_float_seq.sv
// Randomized and directed bench for fix_to_float_seq against an arithmetic float model.
module tb_fix_to_float_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fix_to_float_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // value = v / 2^16; float = 1.m * 2^(msb-16)
    function automatic logic [31:0] ref_float(input logic [31:0] v);
        int msb, e, s;
        longint unsigned m, r, half;
        if (v == 0) return 32'h0;
        msb = 31;
        while (!v[msb]) msb--;
        e = msb - 16 + 127;
        if (msb <= 23) begin
            m = longint'(v) << (23 - msb);
        end else begin
            s = msb - 23;
            m = longint'(v) >> s;
`ifdef FIX2FLT_ROUND_RNE_EN
            r    = longint'(v) - (m << s);
            half = 64'd1 << (s - 1);
            if (r > half || (r == half && m[0])) m = m + 1;
            if (m == (64'd1 << 24)) begin
                m = m >> 1;
                e = e + 1;
            end
`else
            r = 0; half = 0;
`endif
        end
        return {1'b0, e[7:0], m[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] v);
        return (v == 0 || v[31:16] != 0) ? 3 : 4;
    endfunction

    // Drives one operand with out_ready=1; lat counts cycles from the accept cycle to first out_valid.
    task automatic convert(input logic [31:0] v, output logic [31:0] d, output logic z, output int lat);
        int n = 0;
        in_data = v; in_valid = 1'b1; out_ready = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        d = out_data; z = out_zero;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] vec [5] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] d; logic z; int lat;
        for (int i = 0; i < 5; i++) begin
            convert(vec[i], d, z, lat);
            checks++; if (d !== ref_float(vec[i])) begin errors++; $display("FAIL dir_data in=%h got=%h exp=%h", vec[i], d, ref_float(vec[i])); end
            checks++; if (z !== (vec[i] == 0)) begin errors++; $display("FAIL dir_zero in=%h got=%b exp=%b", vec[i], z, vec[i] == 0); end
            checks++; if (lat != ref_lat(vec[i])) begin errors++; $display("FAIL dir_latency in=%h got=%0d exp=%0d", vec[i], lat, ref_lat(vec[i])); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, d; logic z; int lat;
        for (int i = 0; i < 60; i++) begin
            case (i % 3)
                0: v = $urandom;
                1: v = $urandom >> $urandom_range(0, 31);
                default: v = 32'h1 << $urandom_range(0, 31);
            endcase
            convert(v, d, z, lat);
            checks++; if (d !== ref_float(v) || z !== (v == 0)) begin errors++; $display("FAIL rand_data in=%h got=%h/%b exp=%h/%b", v, d, z, ref_float(v), v == 0); end
            checks++; if (lat != ref_lat(v)) begin errors++; $display("FAIL rand_latency in=%h got=%0d exp=%0d", v, lat, ref_lat(v)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int n = 0;
        in_data = 32'h0001_0000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_done got=%b exp=1", out_valid); end
        held = out_data;
        in_valid = 1'b1; in_data = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_stall cyc=%0d data=%h exp=%h valid=%b in_ready=%b", i, out_data, held, out_valid, in_ready); end
        end
        checks++; if (held !== 32'h3F80_0000) begin errors++; $display("FAIL bp_held_value got=%h exp=3f800000", held); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept busy=%b in_ready=%b exp=1/0", busy, in_ready); end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== ref_float(32'h1234_5678) || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_new_result got=%h exp=%h", out_data, ref_float(32'h1234_5678)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic z; int lat; int seen = 0;
        in_data = 32'h0000_0100; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rstmid_state out_valid=%b busy=%b in_ready=%b exp=0/0/1", out_valid, busy, in_ready); end
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_pulse got=%0d exp=0", seen); end
        convert(32'h0002_0000, d, z, lat);
        checks++; if (d !== 32'h4000_0000 || z !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%h/%b exp=40000000/0", d, z); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
